latch_bank_wr_ctrl: RTL

//  - Synchronous write sequencer driving a bank of DEPTH x DATA_W level-sensitive latch cells
//    (D, active-low gate GN, output Q). Sits directly upstream of the latch bank.
//  - Converts a single-clock REQ/ACK write request into a glitch-free setup / open / hold gate

---
 rtl/latch_bank_wr_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a DEPTH x DATA_W latch bank: turns a req/ack write into a
// setup / open / hold gate sequence. Optional flop shadow copy: LATCH_BANK_SHADOW_EN.
module latch_bank_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] d,
  output logic [DEPTH-1:0]  gn,
  output logic [1:0]        state_dbg
`ifdef LATCH_BANK_SHADOW_EN
  ,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`endif
);

  // Handshake: req is a level sampled only on edges where the FSM is idle; the
  // write is accepted on that edge. ack is a one-cycle pulse marking completion,
  // err qualifies ack. Requests while busy are dropped, not queued.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                addr_ok_q;
  logic                capture;
  logic                addr_ok_in;
  logic [DEPTH-1:0]    gn_d;
  logic                ack_d, err_d, busy_d;

  assign capture    = (state_q == IDLE) && req;
  assign addr_ok_in = ({1'b0, addr} < DEPTH_W);
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP:   state_d = OPEN;
      OPEN:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  // An out-of-range address matches no gate line, keeping gn all ones.
  always_comb begin
    gn_d = '1;
    if (state_d == OPEN) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q == ADDR_W'(i)) gn_d[i] = 1'b0;
      end
    end
    ack_d  = (state_d == HOLD);
    err_d  = (state_d == HOLD) && !addr_ok_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      addr_ok_q <= 1'b1;
      d         <= '0;
      gn        <= '1;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      gn      <= gn_d;
      ack     <= ack_d;
      err     <= err_d;
      busy    <= busy_d;
      if (capture) begin
        addr_q    <= addr;
        addr_ok_q <= addr_ok_in;
        d         <= wdata;
      end
    end
  end

`ifdef LATCH_BANK_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [DEPTH];

  // Shadow word updates on the edge that closes the open window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (state_q == OPEN) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q == ADDR_W'(i)) shadow_q[i] <= d;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = shadow_q[i];
    end
  end
`endif

endmodule
